// File: rtl/wb_arbiter_pkg.sv
// Shared writeback types and widths for the register-file write-port arbiter.
package wb_arbiter_pkg;

  localparam int WD_SIZE        = 32;
  localparam int INSTR_REG_SIZE = 5;
  localparam int WB_FIFO_DEPTH  = 2;

  typedef struct packed {
    logic [INSTR_REG_SIZE-1:0] rd;
    logic [WD_SIZE-1:0]        data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// In-order skid FIFO for ALU writeback entries; dout is the head, read combinationally.
// Push while full is ignored unless a pop happens in the same cycle.
module wb_fifo
  import wb_arbiter_pkg::*;
#(
  parameter int DEPTH = WB_FIFO_DEPTH
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic                       pop,
  input  wb_entry_t                  din,
  output wb_entry_t                  dout,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  wb_entry_t     mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ptr_next(wr_ptr);
      end
      if (do_pop)
        rd_ptr <= ptr_next(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Merges ALU and mul/div results onto the single RF write port (mul > FIFO head > ALU), 1-cycle latency.
// Stall back to issue when the ALU skid FIFO is full; a push into a full FIFO is dropped and flagged sticky.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH = WB_FIFO_DEPTH
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      alu_valid_i,
  input  logic                      alu_reg_write_i,
  input  logic [INSTR_REG_SIZE-1:0] alu_rd_i,
  input  logic [WD_SIZE-1:0]        alu_data_i,
  input  logic                      mul_valid_i,
  input  logic                      mul_reg_write_i,
  input  logic [INSTR_REG_SIZE-1:0] mul_rd_i,
  input  logic [WD_SIZE-1:0]        mul_data_i,
  output logic                      rf_we_o,
  output logic [INSTR_REG_SIZE-1:0] rf_waddr_o,
  output logic [WD_SIZE-1:0]        rf_wdata_o,
  output logic                      stall_o,
  output logic                      overflow_o
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic          m_req;
  logic          a_req;
  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_empty;
  logic          fifo_full;
  logic [CW-1:0] fifo_count;
  wb_entry_t     alu_entry;
  wb_entry_t     fifo_head;

  assign m_req = mul_valid_i & mul_reg_write_i & (mul_rd_i != '0);
  assign a_req = alu_valid_i & alu_reg_write_i & (alu_rd_i != '0);

  // ALU bypasses the FIFO only when nothing older is queued and the mul is idle.
  assign fifo_pop  = ~m_req & ~fifo_empty;
  assign fifo_push = a_req & (m_req | ~fifo_empty);

  assign alu_entry = '{rd: alu_rd_i, data: alu_data_i};
  assign stall_o   = (fifo_count == CW'(FIFO_DEPTH));

  wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .din     (alu_entry),
    .dout    (fifo_head),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .count   (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rf_we_o    <= 1'b0;
      rf_waddr_o <= '0;
      rf_wdata_o <= '0;
      overflow_o <= 1'b0;
    end else begin
      if (fifo_push & fifo_full & ~fifo_pop)
        overflow_o <= 1'b1;
      if (m_req) begin
        rf_we_o    <= 1'b1;
        rf_waddr_o <= mul_rd_i;
        rf_wdata_o <= mul_data_i;
      end else if (~fifo_empty) begin
        rf_we_o    <= 1'b1;
        rf_waddr_o <= fifo_head.rd;
        rf_wdata_o <= fifo_head.data;
      end else if (a_req) begin
        rf_we_o    <= 1'b1;
        rf_waddr_o <= alu_rd_i;
        rf_wdata_o <= alu_data_i;
      end else begin
        rf_we_o    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios plus random traffic against a queue-based reference model.
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  localparam int DEPTH = WB_FIFO_DEPTH;

  logic                      clk = 1'b0;
  logic                      reset_n;
  logic                      alu_valid, alu_reg_write, mul_valid, mul_reg_write;
  logic [INSTR_REG_SIZE-1:0] alu_rd, mul_rd;
  logic [WD_SIZE-1:0]        alu_data, mul_data;
  logic                      rf_we, stall, overflow;
  logic [INSTR_REG_SIZE-1:0] rf_waddr;
  logic [WD_SIZE-1:0]        rf_wdata;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  wb_entry_t                 q[$];
  logic                      exp_we;
  logic [INSTR_REG_SIZE-1:0] exp_waddr;
  logic [WD_SIZE-1:0]        exp_wdata;
  logic                      exp_ovf;

  always #5 clk = ~clk;

  wb_arbiter dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .alu_valid_i     (alu_valid),
    .alu_reg_write_i (alu_reg_write),
    .alu_rd_i        (alu_rd),
    .alu_data_i      (alu_data),
    .mul_valid_i     (mul_valid),
    .mul_reg_write_i (mul_reg_write),
    .mul_rd_i        (mul_rd),
    .mul_data_i      (mul_data),
    .rf_we_o         (rf_we),
    .rf_waddr_o      (rf_waddr),
    .rf_wdata_o      (rf_wdata),
    .stall_o         (stall),
    .overflow_o      (overflow)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Advance the reference model by one clock edge with the given inputs.
  task automatic model_edge(input logic rst_n, input logic av, input logic aw, input logic [4:0] ard,
                            input logic [31:0] adat, input logic mv, input logic mw,
                            input logic [4:0] mrd, input logic [31:0] mdat);
    logic      a, m;
    wb_entry_t e;
    if (!rst_n) begin
      q.delete();
      exp_we = 1'b0; exp_waddr = '0; exp_wdata = '0; exp_ovf = 1'b0;
      return;
    end
    m = mv && mw && (mrd != 0);
    a = av && aw && (ard != 0);
    if (m) begin
      exp_we = 1'b1; exp_waddr = mrd; exp_wdata = mdat;
      if (a) begin
        if (q.size() < DEPTH) q.push_back('{rd: ard, data: adat});
        else exp_ovf = 1'b1;
      end
    end else if (q.size() > 0) begin
      e = q.pop_front();
      exp_we = 1'b1; exp_waddr = e.rd; exp_wdata = e.data;
      if (a) q.push_back('{rd: ard, data: adat});
    end else if (a) begin
      exp_we = 1'b1; exp_waddr = ard; exp_wdata = adat;
    end else begin
      exp_we = 1'b0;
    end
  endtask

  // Drive one cycle of inputs (at negedge), then compare all outputs at the next negedge.
  task automatic cycle(input string tag, input logic rst_n, input logic av, input logic aw,
                       input logic [4:0] ard, input logic [31:0] adat, input logic mv,
                       input logic mw, input logic [4:0] mrd, input logic [31:0] mdat);
    reset_n = rst_n;
    alu_valid = av; alu_reg_write = aw; alu_rd = ard; alu_data = adat;
    mul_valid = mv; mul_reg_write = mw; mul_rd = mrd; mul_data = mdat;
    model_edge(rst_n, av, aw, ard, adat, mv, mw, mrd, mdat);
    @(negedge clk);
    check_eq({tag, ".we"},    32'(rf_we),    32'(exp_we));
    check_eq({tag, ".waddr"}, 32'(rf_waddr), 32'(exp_waddr));
    check_eq({tag, ".wdata"}, rf_wdata,      exp_wdata);
    check_eq({tag, ".stall"}, 32'(stall),    32'(q.size() == DEPTH));
    check_eq({tag, ".ovf"},   32'(overflow), 32'(exp_ovf));
  endtask

  task automatic idle(input string tag);
    cycle(tag, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
  endtask

  task automatic do_reset(input string tag);
    cycle(tag, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
  endtask

  initial begin
    reset_n = 1'b0;
    alu_valid = 0; alu_reg_write = 0; alu_rd = 0; alu_data = 0;
    mul_valid = 0; mul_reg_write = 0; mul_rd = 0; mul_data = 0;
    @(negedge clk);
    do_reset("reset");
    do_reset("reset");

    // Solo ALU bypass
    cycle("solo", 1, 1, 1, 5'd3, 32'h11, 0, 0, 5'd0, 32'h0);
    check_eq("solo.addr_const", 32'(rf_waddr), 32'd3);
    idle("solo_idle");

    // Collision: mul wins, ALU follows a cycle later
    cycle("coll0", 1, 1, 1, 5'd6, 32'h22, 1, 1, 5'd5, 32'hAAAA);
    check_eq("coll.mul_const", rf_wdata, 32'hAAAA);
    idle("coll1");
    check_eq("coll.alu_const", 32'(rf_waddr), 32'd6);
    idle("coll2");

    // Ordering: queued ALU entry drains before a later ALU result
    cycle("ord0", 1, 1, 1, 5'd6, 32'h66, 1, 1, 5'd5, 32'h55);
    cycle("ord1", 1, 1, 1, 5'd7, 32'h77, 0, 0, 5'd0, 32'h0);
    idle("ord2");
    check_eq("ord.third_const", 32'(rf_waddr), 32'd7);
    idle("ord3");

    // Fill to full, then drain
    cycle("full0", 1, 1, 1, 5'd8, 32'h80, 1, 1, 5'd9, 32'h90);
    cycle("full1", 1, 1, 1, 5'd10, 32'hA0, 1, 1, 5'd11, 32'hB0);
    check_eq("full.stall_const", 32'(stall), 32'd1);
    idle("full2");
    idle("full3");
    idle("full4");
    idle("full5");

    // Filtering of non-qualifying requests
    cycle("filt_mrd0", 1, 0, 0, 5'd0, 32'h0, 1, 1, 5'd0, 32'hDEAD);
    cycle("filt_aw0",  1, 1, 0, 5'd4, 32'h44, 0, 0, 5'd0, 32'h0);
    cycle("filt_ard0", 1, 1, 1, 5'd0, 32'h45, 0, 0, 5'd0, 32'h0);
    check_eq("filt.we_const", 32'(rf_we), 32'd0);

    // Reset with two entries queued
    cycle("rst0", 1, 1, 1, 5'd12, 32'hC0, 1, 1, 5'd13, 32'hD0);
    cycle("rst1", 1, 1, 1, 5'd14, 32'hE0, 1, 1, 5'd15, 32'hF0);
    do_reset("rst_mid");
    idle("rst_after0");
    idle("rst_after1");
    check_eq("rst.no_stale_const", 32'(rf_we), 32'd0);

    // Protocol violation: push into a full FIFO without a pop must set the sticky flag
    cycle("ovf0", 1, 1, 1, 5'd1, 32'h1, 1, 1, 5'd2, 32'h2);
    cycle("ovf1", 1, 1, 1, 5'd3, 32'h3, 1, 1, 5'd4, 32'h4);
    cycle("ovf2", 1, 1, 1, 5'd5, 32'h5, 1, 1, 5'd6, 32'h6);
    check_eq("ovf.flag_const", 32'(overflow), 32'd1);
    idle("ovf3");
    idle("ovf4");
    idle("ovf5");
    do_reset("ovf_clear");

    // Random traffic honouring the stall
    for (int i = 0; i < 3000; i++) begin
      logic rst_n, av, aw, mv, mw;
      logic [4:0] ard, mrd;
      rst_n = ($urandom_range(0, 299) != 0);
      av  = ($urandom_range(0, 99) < 70) && (q.size() != DEPTH);
      aw  = ($urandom_range(0, 9) != 0);
      ard = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      mv  = ($urandom_range(0, 99) < 35);
      mw  = ($urandom_range(0, 9) != 0);
      mrd = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      cycle("rand", rst_n, av, aw, ard, $urandom, mv, mw, mrd, $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
